sar_adc_sampler: RTL and testbench
==================================

Name: sar_adc_sampler

Overview:
Initiator side of the SAR converter's start/eoc/den/Dout interface.
- Issues periodic start pulses to the SAR converter and captures each result.
- Averages 2^AVG_LOG2 consecutive samples and presents the average on a valid/ready output port.
- Flags missed sample ticks, conversion timeouts and output overruns so software can judge data integrity.

Parameters:
ADC_WIDTH, 8, converter result width; must equal the converter's ADC_WIDTH.
PERIOD_W, 16, width of the sample-period input.
AVG_LOG2, 2, log2 of samples per average (0 = no averaging); range 0..8.
TIMEOUT, 2*ADC_WIDTH+8, clocks allowed in WAIT before abort.

Ports:
clk  in  1  single clock; all logic rises on posedge clk
rst_n  in  1  synchronous, active-low reset, sampled on posedge clk
en  in  1  sampling enable
period  in  PERIOD_W  sample interval in clocks; 0 is treated as 1
clr  in  1  one-cycle pulse; clears sticky flags
eoc  in  1  converter end-of-conversion pulse
den  in  1  converter result-valid
din  in  ADC_WIDTH  converter Dout
start  out  1  converter start; one-cycle high pulse
busy  out  1  high in TRIG or WAIT
avg_data  out  ADC_WIDTH  averaged result
avg_valid  out  1  avg_data valid
avg_ready  in  1  consumer accepts avg_data
miss  out  1  sticky: tick occurred while not IDLE
timeout_err  out  1  sticky: WAIT exceeded TIMEOUT
overrun  out  1  sticky: new average dropped because output was held

Behaviour:
- Reset (rst_n low at a clock edge): all outputs 0; state IDLE; tick counter, sample counter and accumulator cleared. Reset mid-conversion aborts immediately, with no further start pulses.
- Tick generator: while en=1, a counter counts 0..max(period,1)-1 and emits a one-cycle tick on wrap.
  - When en=0 the counter holds at 0.
  - The first tick comes max(period,1) cycles after en rises.
  - A period change takes effect at the next wrap.
- FSM states: IDLE, TRIG, WAIT, ACC.
  - IDLE: on tick with en=1, go to TRIG.
  - TRIG: start=1 for exactly this cycle; go to WAIT. Start is therefore low for at least one cycle between pulses, which guarantees a rising edge.
  - WAIT: a timeout counter counts cycles.
    - eoc=1 and den=1 in the same cycle: capture din and go to ACC.
    - Counter reaches TIMEOUT: set timeout_err, discard the sample and go to IDLE. The sample counter and accumulator are unchanged.
  - ACC (one cycle): sum += captured sample; samples += 1. When samples reaches 2^AVG_LOG2:
    - Compute average = sum >> AVG_LOG2 (truncating).
    - If avg_valid=0 or avg_ready=1 this cycle, load avg_data and set avg_valid=1. Otherwise set overrun and drop the new average; avg_data is held.
    - Clear sum and samples in either case.
    - Then go to IDLE.
- Any tick arriving while the state is not IDLE sets miss; the tick is not queued.
- en falling: the in-flight conversion completes normally (TRIG/WAIT/ACC run to IDLE), and no new triggers are issued. On the first IDLE cycle with en=0, a partial accumulation (samples between 0 and 2^AVG_LOG2 exclusive) is discarded.
- Accumulator width is ADC_WIDTH+AVG_LOG2 and can never overflow.
- Output handshake:
  - avg_valid stays high until a cycle with avg_ready=1; avg_data is stable while valid.
  - Accept and reload in the same cycle is allowed: the new data appears, valid stays 1, and there is no overrun.
- clr clears all sticky flags. If clr and a flag-setting event occur in the same cycle, the set wins.
- Latency: tick to start is 1 cycle. With the SAR converter, the start pulse to eoc is ADC_WIDTH+3 cycles. eoc to avg_valid (final sample) is 2 cycles.

Decomposition:
- Shared package sar_pkg:
  - FSM state enum (IDLE/TRIG/WAIT/ACC);
  - default ADC_WIDTH;
  - TIMEOUT formula function.
- One sub-module, sar_tick_gen: the period counter plus en gating, outputting tick. Everything else lives in sar_adc_sampler.

Test Plan:
1. Connect to the SAR converter with a comparator model for input 0xA5. Use ADC_WIDTH=8, AVG_LOG2=2, period=40, avg_ready=1. Expect: four start pulses 40 clocks apart, then avg_valid pulse with avg_data=0xA5; miss=0, timeout_err=0.
2. Inject samples 0x01, 0x02, 0x02, 0x02 (sum 7). Expect avg_data=0x01 (truncation); with inputs all 0xFF, expect avg_data=0xFF with no overflow.
3. Set period=5, which is shorter than a conversion. Expect miss=1 and a start pulse only after each return to IDLE; results still correct. Pulse clr, then expect miss=0.
4. Hold eoc=0. Expect timeout_err=1 exactly TIMEOUT cycles after entering WAIT, then IDLE and a re-trigger at the next tick; sample count unaffected.
5. Hold avg_ready=0 across two completed averages. Expect the first average held, overrun=1 on the second. Then raise avg_ready for one cycle: avg_valid drops, and avg_data still shows the first average.
6. Drop en after 2 of 4 samples with a conversion in flight. Expect that conversion to complete with no further start pulses and the partial sum discarded. Re-enable: expect the next avg_valid only after 4 fresh samples. Assert rst_n=0 mid-WAIT: all outputs 0 on the next edge.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR converter sampler: FSM states,
// default converter width and the WAIT timeout formula.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT,
    ACC
  } state_e;

  localparam int ADC_WIDTH_DEF = 8;

  function automatic int timeout_cycles(input int adc_width);
    return 2 * adc_width + 8;
  endfunction

endpackage

// File: rtl/sar_tick_gen.sv
// Sample-interval tick generator: counts 0..max(period,1)-1 while enabled
// and emits a registered one-cycle tick on each wrap.
module sar_tick_gen #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] last_q;
  logic [PERIOD_W-1:0] last_d;
  logic                tick_q;

  // The terminal count is latched only at a wrap, so a new period takes effect then.
  assign last_d = (period == '0) ? '0 : period - PERIOD_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      last_q <= last_d;
      tick_q <= 1'b0;
    end else if (!en) begin
      cnt_q  <= '0;
      last_q <= last_d;
      tick_q <= 1'b0;
    end else if (cnt_q == last_q) begin
      cnt_q  <= '0;
      last_q <= last_d;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + PERIOD_W'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/sar_adc_sampler.sv
// Initiator for the SAR converter: periodic start pulses, result capture,
// 2^AVG_LOG2 averaging onto a valid/ready port, and sticky integrity flags.
module sar_adc_sampler
  import sar_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int PERIOD_W  = 16,
  parameter int AVG_LOG2  = 2,
  parameter int TIMEOUT   = timeout_cycles(ADC_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [PERIOD_W-1:0]  period,
  input  logic                 clr,
  input  logic                 eoc,
  input  logic                 den,
  input  logic [ADC_WIDTH-1:0] din,
  output logic                 start,
  output logic                 busy,
  output logic [ADC_WIDTH-1:0] avg_data,
  output logic                 avg_valid,
  input  logic                 avg_ready,
  output logic                 miss,
  output logic                 timeout_err,
  output logic                 overrun
);

  localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(1 << AVG_LOG2);

  state_e               state_q;
  logic [ADC_WIDTH-1:0] sample_q;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [AVG_LOG2:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]     tmo_q;
  logic [ADC_WIDTH-1:0] avg_d;
  logic                 start_q, busy_q, avg_valid_q;
  logic [ADC_WIDTH-1:0] avg_data_q;
  logic                 miss_q, tmo_err_q, overrun_q;
  logic                 tick;

  sar_tick_gen #(
    .PERIOD_W(PERIOD_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .period(period),
    .tick  (tick)
  );

  always_comb begin
    acc_d = acc_q + ACC_W'(sample_q);
    cnt_d = cnt_q + (AVG_LOG2 + 1)'(1);
    avg_d = ADC_WIDTH'(acc_d >> AVG_LOG2);
  end

  // Flag clears come first so a same-cycle set lower down takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      avg_data_q  <= '0;
      avg_valid_q <= 1'b0;
      miss_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (clr) begin
        miss_q    <= 1'b0;
        tmo_err_q <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (tick && state_q != IDLE) miss_q <= 1'b1;
      if (avg_valid_q && avg_ready) avg_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!en) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else if (tick) begin
            state_q <= TRIG;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        TRIG: begin
          state_q <= WAIT;
          tmo_q   <= '0;
        end
        WAIT: begin
          if (eoc && den) begin
            sample_q <= din;
            state_q  <= ACC;
            busy_q   <= 1'b0;
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            tmo_err_q <= 1'b1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ACC: begin
          state_q <= IDLE;
          if (cnt_d == FULL) begin
            acc_q <= '0;
            cnt_q <= '0;
            if (!avg_valid_q || avg_ready) begin
              avg_data_q  <= avg_d;
              avg_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start       = start_q;
  assign busy        = busy_q;
  assign avg_data    = avg_data_q;
  assign avg_valid   = avg_valid_q;
  assign miss        = miss_q;
  assign timeout_err = tmo_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sar_adc_sampler.sv
// Directed bench for sar_adc_sampler with a behavioural SAR converter and a
// scoreboard queue of expected averages.
module tb_sar_adc_sampler;

  localparam int ADC_WIDTH = 8;
  localparam int PERIOD_W  = 16;
  localparam int AVG_LOG2  = 2;
  localparam int TIMEOUT   = 24;
  localparam int CONV_LAT  = ADC_WIDTH + 3;

  logic                 clk = 1'b0;
  logic                 rst_n, en, clr, avg_ready;
  logic [PERIOD_W-1:0]  period;
  logic                 eoc = 1'b0, den = 1'b0;
  logic [ADC_WIDTH-1:0] din = '0;
  logic                 start, busy, avg_valid, miss, timeout_err, overrun;
  logic [ADC_WIDTH-1:0] avg_data;

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;
  int startCount = 0;
  int startTimes[$];
  int lastEocCyc = 0;
  int avgCyc = 0;
  logic [ADC_WIDTH-1:0] convQ[$];
  logic [ADC_WIDTH-1:0] expQ[$];
  logic [ADC_WIDTH-1:0] convDefault = 8'h00;
  logic holdEoc = 1'b0;
  logic convActive = 1'b0;
  int convCnt = 0;

  sar_adc_sampler #(
    .ADC_WIDTH(ADC_WIDTH),
    .PERIOD_W (PERIOD_W),
    .AVG_LOG2 (AVG_LOG2),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .period     (period),
    .clr        (clr),
    .eoc        (eoc),
    .den        (den),
    .din        (din),
    .start      (start),
    .busy       (busy),
    .avg_data   (avg_data),
    .avg_valid  (avg_valid),
    .avg_ready  (avg_ready),
    .miss       (miss),
    .timeout_err(timeout_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (start) begin
      startCount++;
      startTimes.push_back(cyc);
    end
  end

  // Converter model: eoc/den pulse with a result CONV_LAT cycles after start.
  always @(negedge clk) begin
    eoc = 1'b0;
    den = 1'b0;
    if (!rst_n) begin
      convActive = 1'b0;
    end else begin
      if (convActive) begin
        convCnt++;
        if (convCnt == CONV_LAT) begin
          eoc = 1'b1;
          den = 1'b1;
          if (convQ.size() > 0) din = convQ.pop_front();
          else din = convDefault;
          convActive = 1'b0;
          lastEocCyc = cyc;
        end
      end
      if (start && !holdEoc) begin
        convActive = 1'b1;
        convCnt = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic enV, input int periodV);
    @(negedge clk);
    period = PERIOD_W'(periodV);
    en = enV;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseClr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic waitAvg(input string tag, input int budget);
    int n;
    logic [ADC_WIDTH-1:0] e;
    n = 0;
    while (!avg_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    avgCyc = cyc;
    checkOutput({tag, "_seen"}, {31'd0, avg_valid}, 32'd1);
    if (avg_valid) begin
      checkOutput({tag, "_sb"}, {31'd0, expQ.size() != 0}, 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput({tag, "_data"}, {24'd0, avg_data}, {24'd0, e});
      end
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return {18'd0, start, busy, avg_valid, miss, timeout_err, overrun, avg_data};
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b, enCyc, n, s0;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; avg_ready = 1'b1; period = 16'd40;
    idle(3);
    checkOutput("reset_outputs", allOutputs(), 32'd0);
    rst_n = 1'b1;

    // 1: constant 0xA5, period 40
    convDefault = 8'hA5;
    expQ.push_back(8'hA5);
    b = startTimes.size();
    applyStimulus(1'b1, 40);
    enCyc = cyc;
    waitAvg("t1", 400);
    en = 1'b0;
    checkOutput("t1_starts", startTimes.size() - b, 4);
    if (startTimes.size() >= b + 4) begin
      checkOutput("t1_first_start", startTimes[b] - enCyc, 41);
      for (int i = 1; i < 4; i++)
        checkOutput("t1_start_gap", startTimes[b+i] - startTimes[b+i-1], 40);
    end
    checkOutput("t1_eoc_to_valid", avgCyc - lastEocCyc, 2);
    checkOutput("t1_miss", {31'd0, miss}, 0);
    checkOutput("t1_timeout", {31'd0, timeout_err}, 0);
    idle(20);

    // 2: truncation and full-scale
    convQ = '{8'h01, 8'h02, 8'h02, 8'h02};
    expQ.push_back(8'h01);
    applyStimulus(1'b1, 20);
    waitAvg("t2_trunc", 300);
    en = 1'b0;
    idle(20);
    convQ = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    expQ.push_back(8'hFF);
    applyStimulus(1'b1, 20);
    waitAvg("t2_full", 300);
    en = 1'b0;
    idle(20);

    // 3: period shorter than a conversion
    convDefault = 8'h33;
    expQ.push_back(8'h33);
    b = startTimes.size();
    applyStimulus(1'b1, 5);
    waitAvg("t3", 300);
    en = 1'b0;
    checkOutput("t3_starts", startTimes.size() - b, 4);
    if (startTimes.size() >= b + 2)
      checkOutput("t3_gap_range", {31'd0, (startTimes[b+1] - startTimes[b]) >= 14 &&
                                          (startTimes[b+1] - startTimes[b]) <= 18}, 1);
    checkOutput("t3_miss_set", {31'd0, miss}, 1);
    idle(30);
    checkOutput("t3_miss_sticky", {31'd0, miss}, 1);
    pulseClr();
    checkOutput("t3_miss_clr", {31'd0, miss}, 0);

    // 4: timeout with eoc held low
    holdEoc = 1'b1;
    convDefault = 8'h50;
    expQ.push_back(8'h50);
    b = startTimes.size();
    applyStimulus(1'b1, 30);
    n = 0;
    while (startTimes.size() == b && n < 100) begin @(negedge clk); n++; end
    s0 = (startTimes.size() > b) ? startTimes[b] : 0;
    n = 0;
    while (!timeout_err && n < 100) begin @(negedge clk); n++; end
    holdEoc = 1'b0;
    checkOutput("t4_timeout_set", {31'd0, timeout_err}, 1);
    checkOutput("t4_timeout_time", cyc - s0, TIMEOUT + 1);
    waitAvg("t4", 400);
    en = 1'b0;
    checkOutput("t4_starts", startTimes.size() - b, 5);
    if (startTimes.size() >= b + 2)
      checkOutput("t4_retrigger", startTimes[b+1] - startTimes[b], 30);
    checkOutput("t4_miss", {31'd0, miss}, 0);
    idle(20);
    pulseClr();
    checkOutput("t4_timeout_clr", {31'd0, timeout_err}, 0);

    // 5: output held, second average overruns
    avg_ready = 1'b0;
    convQ = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
    expQ.push_back(8'h11);
    applyStimulus(1'b1, 20);
    waitAvg("t5_first", 300);
    n = 0;
    while (!overrun && n < 300) begin @(negedge clk); n++; end
    en = 1'b0;
    checkOutput("t5_overrun", {31'd0, overrun}, 1);
    checkOutput("t5_valid_held", {31'd0, avg_valid}, 1);
    checkOutput("t5_data_held", {24'd0, avg_data}, 32'h11);
    idle(20);
    avg_ready = 1'b1;
    @(negedge clk);
    avg_ready = 1'b0;
    checkOutput("t5_valid_drop", {31'd0, avg_valid}, 0);
    checkOutput("t5_data_after", {24'd0, avg_data}, 32'h11);
    avg_ready = 1'b1;
    pulseClr();
    checkOutput("t5_overrun_clr", {31'd0, overrun}, 0);

    // 6: en drop with partial sum, then fresh average
    convQ = '{8'hF0, 8'hF0, 8'hF0, 8'h10, 8'h10, 8'h10, 8'h10};
    expQ.push_back(8'h10);
    b = startCount;
    applyStimulus(1'b1, 20);
    n = 0;
    while (startCount < b + 3 && n < 300) begin @(negedge clk); n++; end
    en = 1'b0;
    idle(60);
    checkOutput("t6_no_more_starts", startCount - b, 3);
    checkOutput("t6_idle_after", {30'd0, busy, avg_valid}, 0);
    applyStimulus(1'b1, 20);
    waitAvg("t6_fresh", 400);
    en = 1'b0;
    checkOutput("t6_fresh_starts", startCount - b, 7);
    idle(20);

    // reset mid-WAIT
    applyStimulus(1'b1, 20);
    n = 0;
    while (!(busy && !start) && n < 100) begin @(negedge clk); n++; end
    checkOutput("rst_in_wait", {31'd0, busy}, 1);
    rst_n = 1'b0;
    b = startCount;
    @(negedge clk);
    checkOutput("rst_mid_wait", allOutputs(), 32'd0);
    en = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(40);
    checkOutput("rst_no_starts", startCount - b, 0);
    checkOutput("sb_drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
